// File: rtl/regfile_wb_pkg.sv
// Shared types for the regfile writeback arbiter: op codes, arbiter states and the
// registered regfile control bundle (sized by WB_W/WB_D, which the arbiter's W/D track).
package regfile_wb_pkg;

    localparam int WB_W = 8;
    localparam int WB_D = 3;

    typedef enum logic [2:0] {
        WR    = 3'd0,
        LDI   = 3'd1,
        CLR   = 3'd2,
        INC   = 3'd3,
        GETOV = 3'd4
    } wb_op_e;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic            RegWrite;
        logic            ClearReg;
        logic            IncReg;
        logic            OvToReg;
        logic            LoadImm;
        logic [WB_D-1:0] writeReg;
        logic [WB_W-1:0] writeValue;
        logic            ovValue;
    } wb_bundle_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= 3'd4;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_picker.sv
// Round-robin one-hot picker: grants the first requester at or after ptr, wrapping at NREQ-1.
module rr_picker #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    // Walk offsets from farthest to nearest so the closest valid requester wins.
    always_comb begin
        grant = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            for (int j = 0; j < NREQ; j++) begin
                if (((int'(ptr) + i) % NREQ) == j && req[j]) begin
                    grant    = '0;
                    grant[j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the regfile write port with lockable grants and a registered control bundle.
// Optional REGFILE_WB_ARB_STATS_EN adds per-requester saturating stall counters on stall_cnt.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int W    = WB_W,
    parameter int D    = WB_D
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              HoldWB,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_lock,
    input  logic [NREQ*3-1:0] req_op,
    input  logic [NREQ*D-1:0] req_addr,
    input  logic [NREQ*W-1:0] req_data,
    input  logic [NREQ-1:0]   req_ov,
    output logic [NREQ-1:0]   req_ready,
    output logic              RegWrite,
    output logic              ClearReg,
    output logic              IncReg,
    output logic              OvToReg,
    output logic              LoadImm,
    output logic [D-1:0]      writeReg,
    output logic [W-1:0]      writeValue,
    output logic              ovValue,
    output logic              illegal_op
`ifdef REGFILE_WB_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0] stall_cnt
`endif
);

    localparam int PW = $clog2(NREQ);

    arb_state_e      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [NREQ-1:0] pick;
    logic [NREQ-1:0] ready;
    logic [PW-1:0]   gidx;
    logic            xfer_p0;
    logic [2:0]      op_p0;
    logic [D-1:0]    addr_p0;
    logic [W-1:0]    data_p0;
    logic            ov_p0;
    wb_bundle_t      bundle_p0, bundle_p1;
    logic            illegal_q;

    function automatic wb_bundle_t decode(input logic [2:0] op, input logic [D-1:0] addr,
                                          input logic [W-1:0] data, input logic ov);
        wb_bundle_t b;
        b = '0;
        if (op_is_legal(op)) begin
            b.RegWrite = 1'b1;
            b.writeReg = WB_D'(addr);
            case (wb_op_e'(op))
                WR:      b.writeValue = WB_W'(data);
                LDI: begin
                    b.LoadImm    = 1'b1;
                    b.writeValue = WB_W'(data);
                end
                CLR:     b.ClearReg = 1'b1;
                INC:     b.IncReg   = 1'b1;
                GETOV: begin
                    b.OvToReg = 1'b1;
                    b.ovValue = ov;
                end
                default: b = '0;
            endcase
        end
        return b;
    endfunction

    rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (pick)
    );

    // Stage p0: grant selection and field mux of the granted requester.
    always_comb begin
        ready = '0;
        if (!HoldWB) begin
            if (state_q == ARB) begin
                ready = pick;
            end else begin
                for (int j = 0; j < NREQ; j++) begin
                    if (owner_q == PW'(j)) ready[j] = req_valid[j];
                end
            end
        end
        gidx    = '0;
        op_p0   = '0;
        addr_p0 = '0;
        data_p0 = '0;
        ov_p0   = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (ready[j]) begin
                gidx    = PW'(j);
                op_p0   = req_op[j*3 +: 3];
                addr_p0 = req_addr[j*D +: D];
                data_p0 = req_data[j*W +: W];
                ov_p0   = req_ov[j];
            end
        end
        xfer_p0   = |(ready & req_valid);
        bundle_p0 = xfer_p0 ? decode(op_p0, addr_p0, data_p0, ov_p0) : '0;
    end

    assign req_ready = ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (!HoldWB) begin
            case (state_q)
                ARB: begin
                    if (xfer_p0) begin
                        ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
                        if (req_lock[gidx]) begin
                            state_d = LOCK;
                            owner_d = gidx;
                        end
                    end
                end
                LOCK: begin
                    // Owner dropping valid also releases the lock.
                    if (!xfer_p0 || !req_lock[gidx]) state_d = ARB;
                end
                default: state_d = ARB;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= ARB;
            ptr_q     <= '0;
            owner_q   <= '0;
            bundle_p1 <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            bundle_p1 <= bundle_p0;
            if (xfer_p0 && !op_is_legal(op_p0)) illegal_q <= 1'b1;
        end
    end

    // Stage p1: registered regfile control bundle.
    assign RegWrite   = bundle_p1.RegWrite;
    assign ClearReg   = bundle_p1.ClearReg;
    assign IncReg     = bundle_p1.IncReg;
    assign OvToReg    = bundle_p1.OvToReg;
    assign LoadImm    = bundle_p1.LoadImm;
    assign writeReg   = D'(bundle_p1.writeReg);
    assign writeValue = W'(bundle_p1.writeValue);
    assign ovValue    = bundle_p1.ovValue;
    assign illegal_op = illegal_q;

`ifdef REGFILE_WB_ARB_STATS_EN
    logic [NREQ-1:0][15:0] stall_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] c, input logic inc);
        return (inc && c != 16'hFFFF) ? c + 16'd1 : c;
    endfunction

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            stall_q <= '0;
        end else begin
            for (int j = 0; j < NREQ; j++) begin
                stall_q[j] <= sat_inc16(stall_q[j], req_valid[j] & ~ready[j]);
            end
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized + directed bench for regfile_wb_arbiter against an integer-level reference model.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int W    = 8;
    localparam int D    = 3;

    logic              CLK = 1'b0;
    logic              RST_n;
    logic              HoldWB;
    logic [NREQ-1:0]   req_valid, req_lock, req_ov, req_ready;
    logic [NREQ*3-1:0] req_op;
    logic [NREQ*D-1:0] req_addr;
    logic [NREQ*W-1:0] req_data;
    logic              RegWrite, ClearReg, IncReg, OvToReg, LoadImm, ovValue, illegal_op;
    logic [D-1:0]      writeReg;
    logic [W-1:0]      writeValue;
`ifdef REGFILE_WB_ARB_STATS_EN
    logic [NREQ*16-1:0] stall_cnt;
    int stall_m [NREQ];
`endif

    int checks = 0;
    int failures = 0;
    int ptr_m, owner_m;
    bit lockd_m, ill_m;
    logic [NREQ-1:0] lastReady;

    always #5 CLK = ~CLK;

    regfile_wb_arbiter #(.NREQ(NREQ), .W(W), .D(D)) dut (
        .CLK(CLK), .RST_n(RST_n), .HoldWB(HoldWB),
        .req_valid(req_valid), .req_lock(req_lock), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .req_ov(req_ov),
        .req_ready(req_ready), .RegWrite(RegWrite), .ClearReg(ClearReg),
        .IncReg(IncReg), .OvToReg(OvToReg), .LoadImm(LoadImm),
        .writeReg(writeReg), .writeValue(writeValue), .ovValue(ovValue),
        .illegal_op(illegal_op)
`ifdef REGFILE_WB_ARB_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int model_grant();
        if (HoldWB) return -1;
        if (lockd_m) return req_valid[owner_m] ? owner_m : -1;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[(ptr_m + i) % NREQ]) return (ptr_m + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        ptr_m = 0; owner_m = 0; lockd_m = 0; ill_m = 0;
`ifdef REGFILE_WB_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) stall_m[i] = 0;
`endif
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".sel"}, 32'({RegWrite, ClearReg, IncReg, OvToReg, LoadImm}), 32'd0);
        check({tag, ".reg"}, 32'(writeReg), 32'd0);
        check({tag, ".val"}, 32'(writeValue), 32'd0);
        check({tag, ".ov"}, 32'(ovValue), 32'd0);
    endtask

    // One clock: check ready at the negedge, then the registered bundle after the posedge.
    task automatic step(input string tag);
        int g;
        logic [2:0] op;
        logic [4:0] selExp;
        logic [31:0] regExp, valExp, ovExp;
        @(negedge CLK);
        g = model_grant();
        lastReady = req_ready;
        check({tag, ".ready"}, 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
`ifdef REGFILE_WB_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && g != i && stall_m[i] < 65535) stall_m[i]++;
        end
`endif
        selExp = '0; regExp = 0; valExp = 0; ovExp = 0;
        if (g >= 0) begin
            op = req_op[g*3 +: 3];
            if (op <= 3'd4) begin
                selExp = {1'b1, op == 3'd2, op == 3'd3, op == 3'd4, op == 3'd1};
                regExp = 32'(req_addr[g*D +: D]);
                if (op <= 3'd1) valExp = 32'(req_data[g*W +: W]);
                if (op == 3'd4) ovExp = 32'(req_ov[g]);
            end else begin
                ill_m = 1;
            end
        end
        if (!HoldWB) begin
            if (lockd_m) begin
                if (g < 0 || !req_lock[g]) lockd_m = 0;
            end else if (g >= 0) begin
                ptr_m = (g + 1) % NREQ;
                if (req_lock[g]) begin
                    lockd_m = 1;
                    owner_m = g;
                end
            end
        end
        @(posedge CLK);
        #1;
        check({tag, ".sel"}, 32'({RegWrite, ClearReg, IncReg, OvToReg, LoadImm}), 32'(selExp));
        check({tag, ".reg"}, 32'(writeReg), regExp);
        check({tag, ".val"}, 32'(writeValue), valExp);
        check({tag, ".ov"}, 32'(ovValue), ovExp);
        check({tag, ".ill"}, 32'(illegal_op), 32'(ill_m));
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_lock = '0; req_op = '0; req_addr = '0;
        req_data = '0; req_ov = '0; HoldWB = 1'b0;
    endtask

    initial begin
        idle_inputs();
        RST_n = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check_idle_outputs("rst");
        check("rst.ready", 32'(req_ready), 32'd0);
        check("rst.ill", 32'(illegal_op), 32'd0);
        @(negedge CLK) RST_n = 1'b1;
        @(posedge CLK);
        #1;

        // Single WR from req0.
        req_valid = 3'b001; req_op[2:0] = 3'd0; req_addr[2:0] = 3'd3; req_data[7:0] = 8'h5A;
        step("t1");
        check("t1.rw", 32'(RegWrite), 32'd1);
        check("t1.addr", 32'(writeReg), 32'd3);
        check("t1.data", 32'(writeValue), 32'h5A);
        idle_inputs();

        // Bring pointer back to 0, then all three valid for six cycles.
        req_valid = 3'b100;
        step("t2pre");
        req_valid = 3'b111;
        req_op = {3'd3, 3'd2, 3'd1};
        req_addr = {3'd7, 3'd5, 3'd1};
        req_data = {8'hC3, 8'h81, 8'h24};
        for (int k = 0; k < 6; k++) begin
            step("t2");
            check("t2.rr", 32'(lastReady), 32'd1 << (k % 3));
            check("t2.rw", 32'(RegWrite), 32'd1);
        end

        // req1 locks for three beats while req0/req2 wait, then req2 is next.
        req_valid = 3'b010; req_lock = 3'b010;
        step("t3a");
        check("t3.b1", 32'(lastReady), 32'b010);
        req_valid = 3'b111;
        step("t3b");
        check("t3.b2", 32'(lastReady), 32'b010);
        req_lock = 3'b000;
        step("t3c");
        check("t3.b3", 32'(lastReady), 32'b010);
        req_valid = 3'b101;
        step("t3d");
        check("t3.next", 32'(lastReady), 32'b100);

        // HoldWB freezes grants.
        req_valid = 3'b001; HoldWB = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step("t4h");
            check("t4.ready", 32'(lastReady), 32'd0);
            check("t4.rw", 32'(RegWrite), 32'd0);
        end
        HoldWB = 1'b0;
        step("t4r");
        check("t4.resume", 32'(lastReady), 32'b001);

        // Illegal op from req2 is accepted and sticks.
        idle_inputs();
        req_valid = 3'b100; req_op = {3'd6, 3'd0, 3'd0};
        step("t5");
        check("t5.ready", 32'(lastReady), 32'b100);
        check("t5.rw", 32'(RegWrite), 32'd0);
        check("t5.ill", 32'(illegal_op), 32'd1);
        idle_inputs();
        step("t5idle");
        check("t5.sticky", 32'(illegal_op), 32'd1);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            req_valid = NREQ'($urandom);
            req_lock = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
            for (int i = 0; i < NREQ; i++) begin
                req_op[i*3 +: 3] = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7))
                                                                 : 3'($urandom_range(0, 4));
            end
            req_addr = (NREQ*D)'($urandom);
            req_data = (NREQ*W)'($urandom);
            req_ov = NREQ'($urandom);
            HoldWB = ($urandom_range(0, 7) == 0);
            step("rnd");
        end

`ifdef REGFILE_WB_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) check("stall", 32'(stall_cnt[i*16 +: 16]), 32'(stall_m[i]));
`endif

        // Asynchronous reset while req0 holds the lock.
        idle_inputs();
        req_valid = 3'b001; req_lock = 3'b001; req_op[2:0] = 3'd1; req_data[7:0] = 8'hE7;
        step("t6a");
        step("t6b");
        check("t6.locked_rw", 32'(RegWrite), 32'd1);
        req_valid = '0;
        #2;
        RST_n = 1'b0;
        #1;
        check_idle_outputs("t6rst");
        check("t6rst.ready", 32'(req_ready), 32'd0);
        check("t6rst.ill", 32'(illegal_op), 32'd0);
        model_reset();
        @(negedge CLK) RST_n = 1'b1;
        @(posedge CLK);
        #1;
        req_valid = 3'b111; req_lock = '0;
        step("t6post");
        check("t6.ptr0", 32'(lastReady), 32'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
